// File: rtl/br_pkg.sv
// Shared types and defaults for the branch resolver and its neighbouring
// pipeline stages (predictor, execute).
package br_pkg;

  localparam int BR_DEPTH_DEF = 4;
  localparam int BR_CNT_W_DEF = 16;

  // Branch direction as seen by predictor and execute.
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } br_dir_t;

  // Resolution record: execute reports the actual direction of the oldest branch.
  typedef struct packed {
    logic    valid;
    br_dir_t taken;
  } br_res_t;

  // Convert a raw direction bit into the enum type.
  function automatic br_dir_t to_dir(input logic b);
    return b ? TAKEN : NOT_TAKEN;
  endfunction

endpackage

// File: rtl/br_pred_fifo.sv
// Program-order queue of issued predictions.
// Head is read combinationally so the resolve compare happens in the same
// cycle as res_valid; the array is tiny, so distributed storage is used.
// clear empties the queue at the next edge and wins over a same-cycle push.
module br_pred_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = BR_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  br_dir_t        push_dir,
  input  logic           pop,
  input  logic           clear,
  output br_dir_t        head_dir,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  br_dir_t          mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign head_dir = mem_reg[rd_ptr_reg];

  // Guard against overflow/underflow even if the caller forgets to.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage write at the tail; contents need no reset since count gates use.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_dir;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Closes the branch predictor training loop: queues predictions in program
// order, pairs the oldest with execute's actual outcome, emits a registered
// training strobe and a one-cycle mispredict flush.
// Optional statistics counters are enabled with macro BR_RESOLVER_STATS_EN.
module branch_resolver
  import br_pkg::*;
#(
  parameter int DEPTH = BR_DEPTH_DEF,
  parameter int CNT_W = BR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             result,
  output logic             taken,
  output logic             flush,
  output logic             flush_taken,
  output logic             underflow,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int PTR_W = $clog2(DEPTH);

  br_res_t          res_in;
  br_dir_t          head_dir;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  logic             unused_count;
  logic             push;
  logic             pop;
  logic             mismatch;

  logic result_reg;
  logic taken_reg;
  logic flush_reg;
  logic flush_taken_reg;
  logic underflow_reg;

  assign res_in.valid = res_valid;
  assign res_in.taken = to_dir(res_taken);

  // Occupancy is only observed through full/empty here.
  assign unused_count = ^count;

  assign pred_ready = !full;
  assign push       = pred_valid && !full;
  assign pop        = res_in.valid && !empty;
  // A wrong prediction squashes all younger entries, including one pushed now.
  assign mismatch   = pop && (head_dir != res_in.taken);

  br_pred_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dir (to_dir(pred_taken)),
    .pop      (pop),
    .clear    (mismatch),
    .head_dir (head_dir),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Registered training/flush pulses, one cycle after the resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg      <= 1'b0;
      taken_reg       <= 1'b0;
      flush_reg       <= 1'b0;
      flush_taken_reg <= 1'b0;
    end else begin
      result_reg      <= pop;
      taken_reg       <= pop && (res_in.taken == TAKEN);
      flush_reg       <= mismatch;
      flush_taken_reg <= mismatch && (res_in.taken == TAKEN);
    end
  end

  // Sticky flag: a resolve arrived with nothing in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_reg <= 1'b0;
    end else if (res_in.valid && empty) begin
      underflow_reg <= 1'b1;
    end
  end

  assign result      = result_reg;
  assign taken       = taken_reg;
  assign flush       = flush_reg;
  assign flush_taken = flush_taken_reg;
  assign underflow   = underflow_reg;

`ifdef BR_RESOLVER_STATS_EN
  logic [CNT_W-1:0] br_count_reg;
  logic [CNT_W-1:0] mp_count_reg;

  // Saturating statistics: resolved and mispredicted branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_reg <= '0;
      mp_count_reg <= '0;
    end else begin
      if (pop && (br_count_reg != '1))      br_count_reg <= br_count_reg + CNT_W'(1);
      if (mismatch && (mp_count_reg != '1)) mp_count_reg <= mp_count_reg + CNT_W'(1);
    end
  end

  assign br_count = br_count_reg;
  assign mp_count = mp_count_reg;
`else
  assign br_count = '0;
  assign mp_count = '0;
`endif

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Sits directly downstream of the 2-bit saturating branch predictor and closes its training loop.
- Queues every issued prediction in program order. Pairs each queued prediction with the actual outcome from execute.
- Drives the predictor's result/taken training inputs and raises a one-cycle mispredict flush to fetch.
- Optionally keeps branch and mispredict statistics.

Parameters:
- DEPTH, 4, max in-flight (predicted, unresolved) branches; power of two, >= 2.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pred_valid  input  1  predictor output valid this cycle (one issued branch).
- pred_taken  input  1  predictor's prediction bit.
- pred_ready  output  1  queue can accept; equals !full, combinational from registered state.
- res_valid  input  1  execute resolved the oldest in-flight branch.
- res_taken  input  1  actual direction.
- result  output  1  training strobe to predictor's result input.
- taken  output  1  actual direction to predictor's taken input.
- flush  output  1  one-cycle mispredict pulse to fetch.
- flush_taken  output  1  correct direction for refetch; valid while flush=1.
- underflow  output  1  sticky: res_valid seen with queue empty.
- br_count  output  CNT_W  resolved branches.
- mp_count  output  CNT_W  mispredicted branches.

Behaviour:
- Reset: queue empty, pointers 0. result, taken, flush, flush_taken and underflow are 0. Counters are 0. Reset mid-operation drops all in-flight entries with no flush.
- Enqueue:
  - Occurs when pred_valid && pred_ready. pred_taken is written at the tail.
  - pred_valid while full: the branch is not accepted. Upstream must hold it. No state change.
- Resolve:
  - Occurs when res_valid && !empty. Pops the head and compares head with res_taken.
  - Next cycle: result=1, taken=res_taken (one-cycle registered latency).
  - On mismatch, also next cycle: flush=1, flush_taken=res_taken.
- Mispredict squash:
  - On a mismatching resolve, every younger entry is discarded (wrong-path). This includes an entry enqueued in the same cycle.
  - The queue becomes empty at the next edge.
  - pred_ready stays as computed for that cycle; the dropped enqueue is not replayed.
- Simultaneous enqueue and correct resolve: both take effect, and occupancy is unchanged. This is legal even when full only if pred_ready was 1, i.e. never at full (no bypass).
- res_valid with queue empty: ignored. result stays 0, underflow sets and holds until rst. An enqueue in the same cycle proceeds.
- Pointers: log2(DEPTH)-bit, wrap modulo DEPTH. Occupancy is a separate (log2(DEPTH)+1)-bit count; full when count==DEPTH.
- Outputs result, taken, flush and flush_taken are registered pulses. They are 0 in any cycle not following a resolve.
- Counters:
  - br_count increments by 1 per resolve; mp_count increments by 1 per mismatch.
  - Both saturate at all-ones and never wrap.

Optional Feature:
- Macro BR_RESOLVER_STATS_EN.
- Defined: br_count and mp_count are implemented as above.
- Undefined: no counter flops; br_count and mp_count are tied to 0. All other behaviour is identical.

Decomposition:
- Package br_pkg:
  - BR_DEPTH_DEF = 4, BR_CNT_W_DEF = 16.
  - typedef br_dir_t (1-bit, NOT_TAKEN=0, TAKEN=1).
  - typedef br_res_t struct {valid, taken} shared with the predictor and execute stages.
- Sub-module br_pred_fifo: synchronous FIFO with push, pop, clear, full, empty and count.
- Top holds compare logic, output registers, sticky flag and counters.

Test Plan:
- Reset then push T,N,T (pred_taken 1,0,1), resolve 1,0,1 -> result pulses on 3 cycles; taken=1,0,1; flush never 1; br_count=3, mp_count=0 (STATS_EN).
- Push 4 entries -> pred_ready=0. A 5th pred_valid is not accepted. Resolve one -> pred_ready=1 the next cycle.
- Push T,T,N, resolve head with res_taken=0 -> flush=1, flush_taken=0 one cycle later; queue empty; mp_count=1. The next res_valid sets underflow.
- Queue holds 1 entry (N). Same cycle: pred_valid (T) and res_valid with res_taken=0 -> count stays 1, head=T, no flush.
- Same as previous but res_taken=1 -> flush=1; the same-cycle entry is dropped; queue empty.
- Assert rst with 3 entries queued -> all outputs 0 next cycle, pred_ready=1, no flush pulse.
- Force br_count to all-ones (CNT_W=4, 16 resolves) -> br_count stays 15 after the 16th resolve.
